// File: rtl/gf2m_163_pkg.sv
// rtl/gf2m_163_pkg.sv - shared constants and FSM encoding for the GF(2^163) reducer
package gf2m_163_pkg;

    localparam int M         = 163;
    localparam int PROD_W    = 325;
    localparam int NUM_TAPS  = 4;
    // Low-order terms of f(x) = x^163 + x^7 + x^6 + x^3 + 1
    localparam int TAPS [NUM_TAPS] = '{7, 6, 3, 0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FOLD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Number of fold cycles needed to clear bits 163..324.
    function automatic int num_steps(input int fold_w);
        return (M - 1 + fold_w - 1) / fold_w;
    endfunction

endpackage

// File: rtl/gf2m_fold_step.sv
// rtl/gf2m_fold_step.sv - one combinational fold of FOLD_W high bits into the low field
module gf2m_fold_step
    import gf2m_163_pkg::*;
#(
    parameter int FOLD_W = 54
) (
    input  logic [PROD_W-1:0] acc_in,
    input  logic [8:0]        base,
    output logic [PROD_W-1:0] acc_out
);

    localparam logic [PROD_W-1:0] H_MASK = {{(PROD_W-FOLD_W){1'b0}}, {FOLD_W{1'b1}}};

    logic [PROD_W-1:0] h;
    logic [PROD_W-1:0] h_sh;

    // x^(base+j) == x^(base-163+j) * (x^7+x^6+x^3+1) mod f(x)
    always_comb begin
        h       = (acc_in >> base) & H_MASK;
        h_sh    = h << (base - 9'(M));
        acc_out = acc_in & ~(H_MASK << base);
        for (int t = 0; t < NUM_TAPS; t++) begin
            acc_out = acc_out ^ (h_sh << TAPS[t]);
        end
    end

endmodule

// File: rtl/gf2m_reduce_163.sv
// rtl/gf2m_reduce_163.sv - multi-cycle reduction of a 325-bit product modulo x^163+x^7+x^6+x^3+1
module gf2m_reduce_163
    import gf2m_163_pkg::*;
#(
    parameter int FOLD_W = 54
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [M-1:0]      out_res,
    output logic              busy
);

    localparam int            N_STEPS   = num_steps(FOLD_W);
    localparam logic [7:0]    LAST_STEP = 8'(N_STEPS - 1);

    state_t            state;
    state_t            state_next;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] fold_out;
    logic [7:0]        step;
    logic [8:0]        base_raw;
    logic [8:0]        base;

    // Folding proceeds top-down; the last window is clamped so it starts at degree 163.
    always_comb begin
        base_raw = 9'(PROD_W) - (9'(step) + 9'd1) * 9'(FOLD_W);
        base     = (base_raw < 9'(M)) ? 9'(M) : base_raw;
    end

    gf2m_fold_step #(.FOLD_W(FOLD_W)) u_fold (
        .acc_in  (acc),
        .base    (base),
        .acc_out (fold_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            step  <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc  <= in_prod;
                        step <= '0;
                    end
                end
                ST_FOLD: begin
                    acc  <= fold_out;
                    step <= step + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_FOLD;
            end
            ST_FOLD: begin
                busy = 1'b1;
                if (step == LAST_STEP) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign out_res = acc[M-1:0];

endmodule

// File: tb/tb_gf2m_reduce_163.sv
// tb/tb_gf2m_reduce_163.sv - randomized model-checked bench for gf2m_reduce_163 at FOLD_W 1, 54, 156
module tb_gf2m_reduce_163;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [324:0] in_prod;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [2:0]   busy;
    logic [162:0] out_res [3];

    int tests = 0;
    int fails = 0;

    int fw    [3] = '{1, 54, 156};
    int nstep [3] = '{162, 3, 2};
    int ph    [3];
    int lat   [3];
    logic [162:0] exp_res [3];

    gf2m_reduce_163 #(.FOLD_W(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_prod(in_prod), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_res(out_res[0]), .busy(busy[0]));
    gf2m_reduce_163 #(.FOLD_W(54)) u_w54 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_prod(in_prod), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_res(out_res[1]), .busy(busy[1]));
    gf2m_reduce_163 #(.FOLD_W(156)) u_w156 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_prod(in_prod), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_res(out_res[2]), .busy(busy[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Polynomial long division by f(x).
    function automatic logic [162:0] ref_reduce(input logic [324:0] p);
        logic [324:0] f;
        logic [324:0] r;
        f = '0;
        f[163] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
        r = p;
        for (int i = 324; i >= 163; i--) begin
            if (r[i]) r = r ^ (f << (i - 163));
        end
        return r[162:0];
    endfunction

    function automatic logic [324:0] clmul(input logic [162:0] a, input logic [162:0] b);
        logic [324:0] p;
        logic [324:0] aw;
        p  = '0;
        aw = {162'b0, a};
        for (int i = 0; i < 163; i++) begin
            if (b[i]) p = p ^ (aw << i);
        end
        return p;
    endfunction

    // Interleaved shift-and-reduce multiply, independent of clmul/ref_reduce.
    function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
        logic [163:0] r;
        r = '0;
        for (int i = 162; i >= 0; i--) begin
            r = r << 1;
            if (r[163]) r = r ^ {1'b1, 155'b0, 8'hC9};
            if (b[i]) r = r ^ {1'b0, a};
        end
        return r[162:0];
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[162:0];
    endfunction

    function automatic logic [324:0] rand325();
        logic [351:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[324:0];
    endfunction

    task automatic check_val(input string name, input logic [162:0] got, input logic [162:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_ctl(input int i, input logic [2:0] want);
        tests++;
        if ({in_ready[i], busy[i], out_valid[i]} !== want) begin
            fails++;
            $display("FAIL ctl_w%0d lat=%0d: {in_ready,busy,out_valid} got %b want %b",
                     fw[i], lat[i], {in_ready[i], busy[i], out_valid[i]}, want);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timeout waiting, got no event want event", name);
    endtask

    // Cycle-level expectation: IDLE accepts, FOLD lasts N cycles, HOLD until out_ready.
    initial begin
        for (int i = 0; i < 3; i++) begin ph[i] = 0; lat[i] = 0; exp_res[i] = '0; end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 3; i++) ph[i] = 0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (ph[i] == 1) begin
                        lat[i]++;
                        if (lat[i] > nstep[i]) ph[i] = 2;
                    end
                    case (ph[i])
                        0: begin
                            check_ctl(i, 3'b100);
                            if (in_valid) begin
                                ph[i] = 1;
                                lat[i] = 0;
                                exp_res[i] = ref_reduce(in_prod);
                            end
                        end
                        1: check_ctl(i, 3'b010);
                        default: begin
                            check_ctl(i, 3'b001);
                            check_val($sformatf("res_w%0d", fw[i]), out_res[i], exp_res[i]);
                            if (out_ready) ph[i] = 0;
                        end
                    endcase
                end
            end
        end
    end

    task automatic wait_all_ready();
        int n;
        n = 0;
        while (!(&in_ready) && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(&in_ready)) timeout_fail("wait_ready");
    endtask

    task automatic run_one(input logic [324:0] p);
        int n;
        wait_all_ready();
        in_prod  = p;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_prod  = rand325();
        n = 0;
        do begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end while (!(&in_ready) && n < 600);
        if (!(&in_ready)) timeout_fail("drain");
        out_ready = 1'b0;
    endtask

    task automatic hold_test(input logic [324:0] p);
        int n;
        wait_all_ready();
        in_prod   = p;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!(&out_valid) && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(&out_valid)) timeout_fail("hold_reach");
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_prod  = rand325();
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (!(&in_ready)) begin
            fails++;
            $display("FAIL hold_release: in_ready got %b want 111", in_ready);
        end
    endtask

    task automatic reset_mid_fold(input logic [324:0] p);
        wait_all_ready();
        in_prod  = p;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_ctl(i, 3'b100);
            check_val($sformatf("rst_res_w%0d", fw[i]), out_res[i], 163'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [324:0] p;
        logic [162:0] a;
        logic [162:0] b;
        logic [162:0] v;
        logic [162:0] w;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_prod   = '0;

        // Hand-derived values that pin the reference model.
        p = 325'd17;
        v = ref_reduce(p);
        check_val("pin_x4p1", v, 163'd17);
        p = '0; p[163] = 1'b1;
        v = ref_reduce(p);
        check_val("pin_x163", v, 163'hC9);
        p = '0; p[324] = 1'b1;
        v = ref_reduce(p);
        w = '0; w[161] = 1'b1; w[12] = 1'b1; w[10] = 1'b1; w[5] = 1'b1; w[1] = 1'b1;
        check_val("pin_x324", v, w);
        a = 163'd2; b = '0; b[162] = 1'b1;
        v = gf_mul(a, b);
        check_val("pin_mul", v, 163'hC9);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_ctl(i, 3'b100);
            check_val($sformatf("reset_res_w%0d", fw[i]), out_res[i], 163'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_one(325'd17);
        p = '0; p[163] = 1'b1;
        run_one(p);
        p = '0; p[324] = 1'b1;
        run_one(p);
        p = {162'b0, rand163()};
        run_one(p);
        p = '1;
        run_one(p);

        p = rand325();
        hold_test(p);

        p = rand325();
        reset_mid_fold(p);
        p = '0; p[324] = 1'b1;
        run_one(p);

        for (int k = 0; k < 20; k++) begin
            p = rand325();
            if (k % 4 == 0) p[324:163] = '0;
            run_one(p);
        end

        for (int k = 0; k < 250; k++) begin
            a = rand163();
            b = rand163();
            if (k == 0) begin a = '1; b = '1; end
            v = ref_reduce(clmul(a, b));
            w = gf_mul(a, b);
            check_val("model_mul", v, w);
            run_one(clmul(a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/gf2m_reduce_163.md
GF2M_REDUCE_163 -- requirements
Module: gf2m_reduce_163

Interface
REQ-001 Parameter: FOLD_W, default 54, number of high-order product bits folded per cycle; legal range 1..156.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  unreduced product present on in_prod.
REQ-005 Port: in_ready  output  1  block can accept a product this cycle.
REQ-006 Port: in_prod  input  325  unreduced GF(2) polynomial product, bit i = coefficient of x^i (karatsuba_162 output format).
REQ-007 Port: out_valid  output  1  out_res holds a fully reduced result.
REQ-008 Port: out_ready  input  1  consumer accepts out_res this cycle.
REQ-009 Port: out_res  output  163  result mod f(x) = x^163+x^7+x^6+x^3+1, bit i = coefficient of x^i.
REQ-010 Port: busy  output  1  high in FOLD state.

Function
REQ-011 The block SHALL implement FSM states IDLE, FOLD, HOLD.
REQ-012 IDLE: in_ready=1; in_valid=1 SHALL load in_prod into a 325-bit accumulator, set step counter to 0, and go to FOLD.
REQ-013 FOLD: each cycle the block SHALL take the top FOLD_W bits still above degree 162 as H (lowest bit at degree 163), clear them, and XOR H, H<<3, H<<6, H<<7 into the accumulator starting at degree 0 relative to H's base minus 163.
REQ-014 The number of fold cycles SHALL be N = ceil(162/FOLD_W); the final step folds only the remaining bits 163..(324-(N-1)*FOLD_W).
REQ-015 After step N the block SHALL go to HOLD with out_valid=1 and out_res = accumulator[162:0]; accumulator bits 163..324 SHALL be zero.
REQ-016 Latency from in_valid&in_ready to out_valid SHALL be N+1 cycles (4 for FOLD_W=54).
REQ-017 HOLD: out_res and out_valid SHALL remain stable until out_ready=1; on out_valid&out_ready the block SHALL return to IDLE.
REQ-018 in_ready SHALL be 0 in FOLD and HOLD; in_valid there is ignored and in_prod is not sampled.
REQ-019 No bypass: a new product is accepted no earlier than the cycle after the handshake that drains HOLD.
REQ-020 Input with all bits 163..324 zero SHALL still take N fold cycles and return in_prod[162:0] unchanged.
REQ-021 Arithmetic SHALL be carry-less (XOR only); no integer addition anywhere in the datapath.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, out_res=0, accumulator=0, step counter=0.
REQ-023 Reset asserted in FOLD or HOLD SHALL abandon the operation with no output handshake; first post-reset acceptance starts a fresh reduction.

Structure
REQ-024 Shared package gf2m_163_pkg SHALL hold M=163, PROD_W=325, field polynomial tap constants {7,6,3,0}, and the FSM state encoding.
REQ-025 One sub-module gf2m_fold_step (combinational: accumulator in, fold base in, accumulator out) SHALL implement REQ-013; FSM and registers stay in the top.

Verification
REQ-026 in_prod=17 (x^4+1, i.e. 5*5 carry-less) -> out_res=17 after 4 cycles (FOLD_W=54).
REQ-027 in_prod=1<<163 -> out_res=0xC9 (x^7+x^6+x^3+1).
REQ-028 in_prod=1<<324 -> out_res = x^161+x^12+x^10+x^5+x^1.
REQ-029 out_ready held 0 for 10 cycles in HOLD -> out_res stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-030 rst_n pulsed low during fold step 2 -> outputs at reset values immediately; next product reduces correctly.
REQ-031 1000 random 163-bit A,B pairs through karatsuba_162 then this block, FOLD_W in {1,54,156} -> out_res equals reference GF(2^163) multiply.
